// File: rtl/data_memory_unit.sv
// Unified instruction/data memory for the multicycle processor: one request at a time,
// byte/half/word little-endian access with configurable wait states and misalign faults.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic          we_q, sign_ext_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          cur_we, cur_sign_ext;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_size;
    logic          enter_resp, fault;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, rd_shifted, load_val, lane_data;
    logic [3:0]    byte_en;

    // Upper address bits are deliberately ignored so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    // With no wait states the access happens on the acceptance edge itself, so the
    // live inputs are used in IDLE and the captured copies afterwards.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cur_we       = we_q;
        cur_sign_ext = sign_ext_q;
        cur_addr     = addr_q;
        cur_wdata    = wdata_q;
        cur_size     = size_q;
        if (state == ST_IDLE) begin
            cur_we       = we;
            cur_sign_ext = sign_ext;
            cur_addr     = addr[AW+1:0];
            cur_wdata    = wdata;
            cur_size     = size;
        end

        enter_resp = (state == ST_IDLE && req && NO_WAIT) ||
                     (state == ST_WAIT && wait_cnt == 4'd0);

        case (cur_size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = cur_addr[0];
            2'b10:   fault = |cur_addr[1:0];
            default: fault = 1'b1;
        endcase

        word_idx   = cur_addr[AW+1:2];
        rd_word    = mem[word_idx];
        rd_shifted = rd_word >> {cur_addr[1:0], 3'b000};

        case (cur_size)
            2'b00:   load_val = {{24{cur_sign_ext & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_val = {{16{cur_sign_ext & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_val = rd_word;
        endcase

        case (cur_size)
            2'b00: begin
                byte_en   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                lane_data = cur_wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                lane_data = cur_wdata;
            end
        endcase
    end

    // NOTE: the storage array has no reset; a reset loop over it would not map to RAM.
    // A reset mid-operation forces IDLE asynchronously, so no commit follows.
    always_ff @(posedge clk) begin
        if (enter_resp && !fault && cur_we) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            rdata      <= 32'd0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            misalign   <= 1'b0;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            size_q     <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q       <= we;
                        sign_ext_q <= sign_ext;
                        addr_q     <= addr[AW+1:0];
                        wdata_q    <= wdata;
                        size_q     <= size;
                        busy       <= 1'b1;
                        wait_cnt   <= WAIT_LOAD;
                        state      <= NO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) state <= ST_RESP;
                    else wait_cnt <= wait_cnt - 4'd1;
                end
                default: begin
                    state    <= ST_IDLE;
                    ready    <= 1'b0;
                    busy     <= 1'b0;
                    misalign <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                ready    <= 1'b1;
                misalign <= fault;
                if (!fault && !cur_we) rdata <= load_val;
            end
        end
    end

endmodule
